// File: rtl/vector_sweep_ctrl_pkg.sv
// Shared types and default sizing for the exhaustive vector sweep sequencer.
package vector_sweep_ctrl_pkg;

  localparam int unsigned N_IN_DEF   = 3;
  localparam int unsigned N_OUT_DEF  = 2;
  localparam int unsigned SETTLE_DEF = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Settle counter width; a one-cycle settle still needs a 1-bit register.
  function automatic int unsigned timer_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/vector_sweep_ctrl_settle_timer.sv
// Clearable up-counter that flags the last settle cycle of a driven vector.
module vector_sweep_ctrl_settle_timer
  import vector_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = timer_width(SETTLE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Sweeps every input vector of a combinational UUT, samples its outputs after
// a settle window and keeps a running tally of all-zero responses.
module vector_sweep_ctrl
  import vector_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned N_OUT  = N_OUT_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             sample_valid,
  output logic [N_IN-1:0]  sample_vec,
  output logic [N_OUT-1:0] sample_out,
  output logic             all_zero,
  output logic [N_IN:0]    zero_count,
  output logic [N_IN-1:0]  first_zero_vec,
  output logic             done
);

  localparam int unsigned ZW = N_IN + 1;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [N_IN-1:0]    dut_in_d;
  logic               busy_d;
  logic               sample_valid_d;
  logic [N_IN-1:0]    sample_vec_d;
  logic [N_OUT-1:0]   sample_out_d;
  logic               all_zero_d;
  logic [N_IN:0]      zero_count_d;
  logic [N_IN-1:0]    first_zero_vec_d;
  logic               done_d;
  logic               expire;
  logic               timer_clear;
  logic               timer_en;

  // Counter only runs in DRIVE and rearms itself on the last settle cycle.
  assign timer_en    = (state_q == ST_DRIVE);
  assign timer_clear = (state_q != ST_DRIVE) || expire;

  vector_sweep_ctrl_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_d          = state_q;
    vec_d            = vec_q;
    sample_valid_d   = 1'b0;
    all_zero_d       = 1'b0;
    done_d           = 1'b0;
    sample_vec_d     = sample_vec;
    sample_out_d     = sample_out;
    zero_count_d     = zero_count;
    first_zero_vec_d = first_zero_vec;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_DRIVE;
          vec_d            = '0;
          zero_count_d     = '0;
          first_zero_vec_d = '0;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          sample_valid_d = 1'b1;
          sample_vec_d   = vec_q;
          sample_out_d   = dut_out;
          all_zero_d     = (dut_out == '0);
          if (dut_out == '0) begin
            zero_count_d = zero_count + ZW'(1);
            if (zero_count == '0) begin
              first_zero_vec_d = vec_q;
            end
          end
          // Completion is the all-ones compare; vec never wraps.
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    dut_in_d = (state_d == ST_IDLE) ? '0 : vec_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      vec_q          <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      sample_valid   <= 1'b0;
      sample_vec     <= '0;
      sample_out     <= '0;
      all_zero       <= 1'b0;
      zero_count     <= '0;
      first_zero_vec <= '0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      dut_in         <= dut_in_d;
      busy           <= busy_d;
      sample_valid   <= sample_valid_d;
      sample_vec     <= sample_vec_d;
      sample_out     <= sample_out_d;
      all_zero       <= all_zero_d;
      zero_count     <= zero_count_d;
      first_zero_vec <= first_zero_vec_d;
      done           <= done_d;
    end
  end

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Bench for vector_sweep_ctrl: table-driven directed sweep, cycle-level
// reference model with random UUT truth tables, aborts, restarts and resets.
module tb_vector_sweep_ctrl;

  localparam int NI    = 3;
  localparam int NO    = 2;
  localparam int ST    = 19;
  localparam int P     = ST + 1;
  localparam int NV    = 8;
  localparam int T_END = NV * P;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort;
  logic [NO-1:0] dut_out;
  logic [NI-1:0] dut_in;
  logic          busy, sample_valid, all_zero, done;
  logic [NI-1:0] sample_vec, first_zero_vec;
  logic [NO-1:0] sample_out;
  logic [NI:0]   zero_count;

  logic       start2;
  logic [1:0] dut_in2, sample_vec2, first_zero_vec2;
  logic [1:0] sample_out2;
  logic       busy2, sample_valid2, all_zero2, done2;
  logic [2:0] zero_count2;

  logic       rand_mode;
  logic [1:0] tt [NV];

  int total = 0;
  int bad   = 0;
  int cur_t = 0;
  int hold_vec = 0;
  logic [1:0] hold_out = 2'b00;

  typedef struct {
    int         vec;
    logic [1:0] out;
    logic       az;
  } vec_rec_t;
  vec_rec_t tbl [NV];

  always #5 clk = ~clk;

  // Bench-side UUT: x=a&b, y=b|c, or a random truth table.
  assign dut_out = rand_mode ? tt[dut_in] : {dut_in[2] & dut_in[1], dut_in[1] | dut_in[0]};

  vector_sweep_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .dut_out        (dut_out),
    .dut_in         (dut_in),
    .busy           (busy),
    .sample_valid   (sample_valid),
    .sample_vec     (sample_vec),
    .sample_out     (sample_out),
    .all_zero       (all_zero),
    .zero_count     (zero_count),
    .first_zero_vec (first_zero_vec),
    .done           (done)
  );

  vector_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SETTLE(1)) dut_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start2),
    .abort          (1'b0),
    .dut_out        (2'b00),
    .dut_in         (dut_in2),
    .busy           (busy2),
    .sample_valid   (sample_valid2),
    .sample_vec     (sample_vec2),
    .sample_out     (sample_out2),
    .all_zero       (all_zero2),
    .zero_count     (zero_count2),
    .first_zero_vec (first_zero_vec2),
    .done           (done2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, cur_t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_out(input int v);
    logic a, b, c;
    if (rand_mode) return tt[v];
    a = v[2];
    b = v[1];
    c = v[0];
    return {a & b, b | c};
  endfunction

  // Cycle-level check of one sweep; t counts edges from the accepting edge.
  task automatic run_sweep(input int t_a, input bit ab0, input int rp1, input int rp2);
    int ns, zc, fz, exp_in;
    bit aborted, sv;
    for (int t = 0; t <= T_END + 3; t++) begin
      start = (t == 0) || (t == rp1) || (t == rp2);
      abort = (t == t_a) || (t == 0 && ab0);
      tick();
      cur_t = t;
      start = 1'b0;
      abort = 1'b0;
      aborted = (t_a > 0) && (t >= t_a);
      ns = aborted ? (t_a - 1) / P : t / P;
      if (ns > NV) ns = NV;
      zc = 0;
      fz = 0;
      for (int v = 0; v < ns; v++) begin
        if (model_out(v) == 2'b00) begin
          if (zc == 0) fz = v;
          zc++;
        end
      end
      sv = !aborted && t > 0 && (t % P) == 0 && t <= T_END;
      if (sv) begin
        hold_vec = t / P - 1;
        hold_out = model_out(hold_vec);
      end
      if (aborted || t > T_END) exp_in = 0;
      else if (t == T_END) exp_in = NV - 1;
      else exp_in = t / P;
      chk("busy", busy, !aborted && t <= T_END);
      chk("dut_in", dut_in, exp_in);
      chk("sample_valid", sample_valid, sv);
      chk("all_zero", all_zero, sv && hold_out == 2'b00);
      chk("done", done, !aborted && t == T_END);
      chk("sample_vec", sample_vec, hold_vec);
      chk("sample_out", sample_out, hold_out);
      chk("zero_count", zero_count, zc);
      chk("first_zero_vec", first_zero_vec, fz);
    end
  endtask

  initial begin
    int ta, r1;
    tbl[0] = '{0, 2'b00, 1'b1};
    tbl[1] = '{1, 2'b01, 1'b0};
    tbl[2] = '{2, 2'b01, 1'b0};
    tbl[3] = '{3, 2'b01, 1'b0};
    tbl[4] = '{4, 2'b00, 1'b1};
    tbl[5] = '{5, 2'b01, 1'b0};
    tbl[6] = '{6, 2'b11, 1'b0};
    tbl[7] = '{7, 2'b11, 1'b0};
    for (int i = 0; i < NV; i++) tt[i] = 2'b00;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start2 = 1'b0;
    rand_mode = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_zero_count", zero_count, 0);
    chk("rst_first_zero", first_zero_vec, 0);
    chk("rst_done", done, 0);
    chk("rst_small_busy", busy2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed sweep against the truth table of x=a&b, y=b|c.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tbl_busy_start", busy, 1);
    for (int i = 0; i < NV; i++) begin
      repeat (P) tick();
      cur_t = (i + 1) * P;
      chk("tbl_valid", sample_valid, 1);
      chk("tbl_vec", sample_vec, tbl[i].vec);
      chk("tbl_out", sample_out, tbl[i].out);
      chk("tbl_all_zero", all_zero, tbl[i].az);
      chk("tbl_done", done, i == NV - 1);
      chk("tbl_busy", busy, 1);
    end
    tick();
    chk("tbl_busy_end", busy, 0);
    chk("tbl_dut_in_end", dut_in, 0);
    chk("tbl_done_end", done, 0);
    chk("tbl_zero_count", zero_count, 2);
    chk("tbl_first_zero", first_zero_vec, 0);
    hold_vec = 7;
    hold_out = 2'b11;

    // Abort in DRIVE with vec=3, re-pulsed start, start+abort in IDLE.
    run_sweep(3 * P + 5, 1'b0, -1, -1);
    run_sweep(-1, 1'b0, 30, 100);
    run_sweep(-1, 1'b1, -1, -1);
    run_sweep(T_END, 1'b0, 50, -1);
    run_sweep(P, 1'b0, -1, -1);

    rand_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NV; i++) tt[i] = 2'($urandom_range(0, 3));
      ta = -1;
      r1 = -1;
      if ($urandom_range(0, 1) == 1) ta = $urandom_range(1, T_END);
      if (ta > 1) r1 = $urandom_range(1, ta - 1);
      else if (ta < 0) r1 = $urandom_range(1, T_END);
      run_sweep(ta, 1'($urandom_range(0, 1)), r1, -1);
    end
    rand_mode = 1'b0;

    // Asynchronous reset while in SAMPLE of vector 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3 * P - 1) tick();
    #2;
    rst_n = 1'b0;
    #1;
    cur_t = -1;
    chk("arst_busy", busy, 0);
    chk("arst_dut_in", dut_in, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_vec", sample_vec, 0);
    chk("arst_out", sample_out, 0);
    chk("arst_zero_count", zero_count, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    hold_vec = 0;
    hold_out = 2'b00;
    run_sweep(-1, 1'b0, -1, -1);

    // Minimal build: two inputs, one settle cycle, outputs stuck at zero.
    for (int t = 0; t <= 11; t++) begin
      start2 = (t == 0);
      tick();
      start2 = 1'b0;
      cur_t = t;
      chk("s_valid", sample_valid2, t > 0 && (t % 2) == 0 && t <= 8);
      chk("s_all_zero", all_zero2, t > 0 && (t % 2) == 0 && t <= 8);
      chk("s_done", done2, t == 8);
      chk("s_busy", busy2, t <= 8);
      chk("s_dut_in", dut_in2, t < 8 ? t / 2 : (t == 8 ? 3 : 0));
      chk("s_zero_count", zero_count2, t / 2 > 4 ? 4 : t / 2);
      chk("s_first_zero", first_zero_vec2, 0);
      if (t > 0 && (t % 2) == 0 && t <= 8) chk("s_vec", sample_vec2, t / 2 - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_sweep_ctrl.md
Name: vector_sweep_ctrl

Overview:
- Hardware sequencer that exhaustively drives every input combination of a combinational unit-under-test.
- Each vector is held for a fixed settle time, then the UUT outputs are sampled and reported.
- All-outputs-zero vectors are flagged and counted.
- Sits beside a combinational lab block (e.g. the 3-in/2-out logic module) on the FPGA board, replacing the simulation-only loop bench with synthesizable sequencing.

Parameters:
- N_IN, 3, number of UUT inputs; sweeps 2**N_IN vectors.
- N_OUT, 2, number of UUT outputs sampled.
- SETTLE, 19, cycles a vector is driven before the sample cycle; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel; honoured in any non-IDLE state.
- dut_out  input  N_OUT  UUT outputs.
- dut_in  output  N_IN  vector driven to UUT; MSB = first UUT input (a), LSB = last (c).
- busy  output  1  high while state != IDLE.
- sample_valid  output  1  one-cycle pulse per sampled vector.
- sample_vec  output  N_IN  vector belonging to the current sample.
- sample_out  output  N_OUT  dut_out captured for that vector.
- all_zero  output  1  qualifies sample_valid: sample_out == 0.
- zero_count  output  N_IN+1  number of all-zero vectors in the last or current sweep.
- first_zero_vec  output  N_IN  lowest vector giving all-zero outputs; valid when zero_count != 0.
- done  output  1  one-cycle pulse when the sweep completes normally.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0, including dut_in, zero_count and first_zero_vec.
- FSM states:
  - IDLE -> DRIVE on start. At the same edge: vec=0, settle counter=0, zero_count=0, first_zero_vec=0.
  - DRIVE: dut_in=vec; counter increments each cycle. After SETTLE DRIVE cycles (counter==SETTLE-1), go to SAMPLE.
  - SAMPLE: one cycle; dut_out is stable. At the closing edge:
    - sample_out<=dut_out, sample_vec<=vec, sample_valid<=1.
    - all_zero<=(dut_out==0).
    - If dut_out==0: zero_count increments; first_zero_vec<=vec if zero_count was 0.
    - If vec==2**N_IN-1: go to DONE and set done<=1. Otherwise vec+1, counter=0, go to DRIVE.
  - DONE: one cycle with busy=1, then IDLE. dut_in returns to 0 on entering IDLE.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - A full sweep occupies 2**N_IN*(SETTLE+1) cycles, plus the DONE cycle.
- Pulses: sample_valid, all_zero and done are single-cycle. sample_vec and sample_out hold their values until the next sample.
- The final sample_valid coincides with done.
- vec is N_IN bits and never wraps mid-sweep; completion is detected on the all-ones compare, not on overflow.
- start while busy: ignored, with no restart.
- start and abort together in IDLE: start wins (abort has no effect in IDLE).
- abort:
  - Next state is IDLE, dut_in goes to 0, and no done pulse is issued.
  - zero_count and first_zero_vec keep their partial-sweep values.
  - abort during SAMPLE suppresses that cycle's capture and sample_valid.
- Reset mid-sweep returns everything to reset values immediately.

Decomposition:
- Shared package/include (sweep_defs): state encodings IDLE/DRIVE/SAMPLE/DONE as localparams (2-bit), and default parameter values.
- One natural sub-module, settle_timer:
  - Loadable up-counter of width clog2(SETTLE).
  - Inputs clear and enable; output expire at SETTLE-1.
- The FSM, vector register and scoreboard live in vector_sweep_ctrl.

Test Plan:
- Bench UUT model x=a&b, y=b|c, defaults; start pulsed at cycle 0:
  - 8 sample_valid pulses, 20 cycles apart, with sample_vec 0..7.
  - sample_out per vector = {x,y}.
  - all_zero only for vectors 000 and 100; zero_count=2, first_zero_vec=0.
  - done coincides with the 8th sample_valid; busy falls one cycle later.
- dut_in stability: dut_in is constant across each 20-cycle window and changes only on the edge after a sample. Check with a 19-cycle monitor.
- abort asserted while vec=3 in DRIVE:
  - busy=0 and dut_in=0 next cycle; no done pulse.
  - zero_count=1 (from 000 only).
- start re-pulsed during a sweep: sweep continues unchanged, with 8 total samples. A fresh start after done clears zero_count to 0, then it re-accumulates to 2.
- rst_n asserted asynchronously mid-cycle during SAMPLE: all outputs are 0 immediately, with no edge required. After release and start, the sweep begins again at vec=0.
- SETTLE=1, N_IN=2 build, UUT dut_out constant 0:
  - 4 samples, 2 cycles apart, all with all_zero=1.
  - zero_count=4, first_zero_vec=0.
